cascade_in_reorder: RTL and testbench

Parametrised input reorder buffer at the head of the FFT cascade. It accepts one complex frame per packet and writes it into one of NUM_BUF frame buffers in bit-reversed or natural order. The transform length is selectable per frame at run time. Completed frames are presented to the first butterfly stage by random-access read, with backpressure toward the source when all buffers are full.

---
 rtl/cascade_pkg.sv | 17 +
 rtl/cascade_in_reorder_if.sv | 37 +++
 rtl/bitrev.sv | 16 +
 rtl/cascade_in_reorder.sv | 201 ++++++++++++++++++++
 tb/tb_cascade_in_reorder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cascade_pkg.sv
// Shared types and width helpers for the FFT cascade input stage.
package cascade_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OVF   = 2'd1,
    ERR_FRAME = 2'd2,
    ERR_SOP   = 2'd3
  } err_code_t;

  function automatic int log2n_w(input int addr_width);
    return $clog2(addr_width + 1);
  endfunction

  localparam int LOG2N_W = log2n_w(9);

endpackage

// File: rtl/cascade_in_reorder_if.sv
// Sample sink, random-access frame source and error status of the reorder buffer.
interface cascade_in_reorder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  localparam int LW = cascade_pkg::log2n_w(ADDR_WIDTH);

  logic [LW-1:0]                cfg_log2n;
  logic                         cfg_bitrev;
  logic                         sink_valid;
  logic                         sink_sop;
  logic                         sink_eop;
  logic signed [DATA_WIDTH-1:0] sink_Re;
  logic signed [DATA_WIDTH-1:0] sink_Im;
  logic                         sink_ready;
  logic [ADDR_WIDTH-1:0]        source_rdaddr;
  logic signed [DATA_WIDTH-1:0] source_Re;
  logic signed [DATA_WIDTH-1:0] source_Im;
  logic [LW-1:0]                source_log2n;
  logic                         source_ready;
  logic                         source_rdack;
  logic                         error;
  logic [1:0]                   err_code;

  modport slave (
    input  cfg_log2n, cfg_bitrev, sink_valid, sink_sop, sink_eop, sink_Re, sink_Im,
    input  source_rdaddr, source_rdack,
    output sink_ready, source_Re, source_Im, source_log2n, source_ready, error, err_code
  );

  modport master (
    output cfg_log2n, cfg_bitrev, sink_valid, sink_sop, sink_eop, sink_Re, sink_Im,
    output source_rdaddr, source_rdack,
    input  sink_ready, source_Re, source_Im, source_log2n, source_ready, error, err_code
  );

endinterface

// File: rtl/bitrev.sv
// Combinational bit-order reversal of a WIDTH-bit word.
module bitrev #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  always_comb begin
    o_dat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_dat[i] = i_dat[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/cascade_in_reorder.sv
// Input reorder buffer for the FFT cascade: frames land bit-reversed or natural in one of NUM_BUF buffers.
// Memory write 1 cycle after acceptance, commit after 2; sink_ready drops once every buffer is full or committing.
module cascade_in_reorder
  import cascade_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MIN_LOG2N  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BUF    = 2
) (
  input logic                 clk,
  input logic                 aclr,
  cascade_in_reorder_if.slave bus
);

  localparam int LW = log2n_w(ADDR_WIDTH);
  localparam int BW = $clog2(NUM_BUF);
  localparam int CW = $clog2(NUM_BUF + 1);
  localparam int MW = BW + ADDR_WIDTH;
  localparam logic [LW-1:0]       L_MIN    = LW'(MIN_LOG2N);
  localparam logic [LW-1:0]       L_MAX    = LW'(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] K_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [BW-1:0]       PTR_LAST = BW'(NUM_BUF - 1);
  localparam logic [CW-1:0]       CNT_FULL = CW'(NUM_BUF);

  // open-frame state
  logic                  r_open;
  logic [LW-1:0]         r_l;
  logic                  r_mode;
  logic [ADDR_WIDTH:0]   r_k;

  // registered input stage
  logic                         r_s1_we;
  logic                         r_s1_commit;
  logic [ADDR_WIDTH-1:0]        r_s1_addr;
  logic signed [DATA_WIDTH-1:0] r_s1_re;
  logic signed [DATA_WIDTH-1:0] r_s1_im;
  logic [LW-1:0]                r_s1_l;

  logic [BW-1:0]                r_wr_ptr;
  logic [BW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic [LW-1:0]                r_buf_l [NUM_BUF];
  logic signed [DATA_WIDTH-1:0] r_mem_re [2**MW];
  logic signed [DATA_WIDTH-1:0] r_mem_im [2**MW];
  logic signed [DATA_WIDTH-1:0] r_rd_re;
  logic signed [DATA_WIDTH-1:0] r_rd_im;
  logic                         r_error;
  err_code_t                    r_err_code;

  logic                  w_sink_ready;
  logic [CW-1:0]         w_occ;
  logic                  w_acc;
  logic                  w_strobe_err;
  logic                  w_in_frame;
  logic [LW-1:0]         w_cfg_l;
  logic [LW-1:0]         w_l;
  logic                  w_mode;
  logic [ADDR_WIDTH:0]   w_k;
  logic [ADDR_WIDTH:0]   w_last;
  logic                  w_past;
  logic                  w_we;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_rev;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_rdack;
  err_code_t             w_err_code;

  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // a commit still in the input stage already claims its buffer
  assign w_occ        = r_count + {{(CW-1){1'b0}}, r_s1_commit};
  assign w_sink_ready = (w_occ != CNT_FULL);

  assign w_acc        = bus.sink_valid && w_sink_ready;
  assign w_strobe_err = !bus.sink_valid && (bus.sink_sop || bus.sink_eop);
  assign w_in_frame   = w_acc && (bus.sink_sop || r_open);
  assign w_cfg_l      = (bus.cfg_log2n < L_MIN) ? L_MIN :
                        (bus.cfg_log2n > L_MAX) ? L_MAX : bus.cfg_log2n;
  assign w_l          = bus.sink_sop ? w_cfg_l : r_l;
  assign w_mode       = bus.sink_sop ? bus.cfg_bitrev : r_mode;
  assign w_k          = bus.sink_sop ? '0 : r_k;
  assign w_last       = (K_ONE << w_l) - K_ONE;
  assign w_past       = (w_k > w_last);
  assign w_we         = w_in_frame && !w_past;
  assign w_commit     = w_we && bus.sink_eop && (w_k == w_last);
  assign w_rdack      = bus.source_rdack && (r_count != '0);

  bitrev #(.WIDTH(ADDR_WIDTH)) u_bitrev (
    .i_dat (w_k[ADDR_WIDTH-1:0]),
    .o_dat (w_rev)
  );

  // reversing all ADDR_WIDTH bits then shifting keeps only the reversed low L bits
  assign w_addr = w_mode ? (w_rev >> (L_MAX - w_l)) : w_k[ADDR_WIDTH-1:0];

  always_comb begin
    w_err_code = ERR_NONE;
    if (w_acc && bus.sink_sop && r_open) begin
      w_err_code = ERR_SOP;
    end else if (w_strobe_err || (w_in_frame && (w_past || (bus.sink_eop && (w_k != w_last))))) begin
      w_err_code = ERR_FRAME;
    end else if (bus.sink_valid && !w_sink_ready) begin
      w_err_code = ERR_OVF;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_open <= 1'b0;
      r_k    <= '0;
      r_l    <= L_MIN;
      r_mode <= 1'b0;
    end else if (w_strobe_err) begin
      r_open <= 1'b0;
    end else if (w_in_frame) begin
      r_l    <= w_l;
      r_mode <= w_mode;
      r_open <= !(bus.sink_eop || w_past);
      r_k    <= w_k + K_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_s1_we     <= 1'b0;
      r_s1_commit <= 1'b0;
    end else begin
      r_s1_we     <= w_we;
      r_s1_commit <= w_commit;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_s1_addr <= w_addr;
      r_s1_re   <= bus.sink_Re;
      r_s1_im   <= bus.sink_Im;
      r_s1_l    <= w_l;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < NUM_BUF; i++) begin
        r_buf_l[i] <= '0;
      end
    end else begin
      if (r_s1_commit) begin
        r_buf_l[r_wr_ptr] <= r_s1_l;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (w_rdack) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (r_s1_commit && !w_rdack) begin
        r_count <= r_count + 1'b1;
      end else if (!r_s1_commit && w_rdack) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_error    <= (w_err_code != ERR_NONE);
      r_err_code <= w_err_code;
    end
  end

  always_ff @(posedge clk) begin
    if (r_s1_we && !aclr) begin
      r_mem_re[{r_wr_ptr, r_s1_addr}] <= r_s1_re;
    end
    r_rd_re <= r_mem_re[{r_rd_ptr, bus.source_rdaddr}];
  end

  always_ff @(posedge clk) begin
    if (r_s1_we && !aclr) begin
      r_mem_im[{r_wr_ptr, r_s1_addr}] <= r_s1_im;
    end
    r_rd_im <= r_mem_im[{r_rd_ptr, bus.source_rdaddr}];
  end

  assign bus.sink_ready   = w_sink_ready;
  assign bus.source_ready = (r_count != '0);
  assign bus.source_log2n = r_buf_l[r_rd_ptr];
  assign bus.source_Re    = r_rd_re;
  assign bus.source_Im    = r_rd_im;
  assign bus.error        = r_error;
  assign bus.err_code     = r_err_code;

endmodule

// File: tb/tb_cascade_in_reorder.sv
// Scoreboard bench for cascade_in_reorder with ADDR_WIDTH=4, NUM_BUF=3.
module tb_cascade_in_reorder;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NB   = 3;
  localparam int MINL = 3;

  typedef logic [15:0][31:0] frame_t;

  logic clk = 1'b0;
  logic aclr;

  always #5 clk = ~clk;

  cascade_in_reorder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cascade_in_reorder #(
    .ADDR_WIDTH (AW),
    .MIN_LOG2N  (MINL),
    .DATA_WIDTH (DW),
    .NUM_BUF    (NB)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  frame_t q_re [$];
  frame_t q_im [$];
  int     q_l  [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev_bits(input int k, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  task automatic idle();
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
  endtask

  task automatic drive_sample(input bit sop, input bit eop, input int v);
    bus.sink_valid = 1'b1;
    bus.sink_sop   = sop;
    bus.sink_eop   = eop;
    bus.sink_Re    = v;
    bus.sink_Im    = -v;
    tick();
  endtask

  task automatic push_model(input int cfg_l, input bit brev, input int base);
    frame_t fr = '0;
    frame_t fi = '0;
    int     l;
    int     a;
    l = (cfg_l < MINL) ? MINL : ((cfg_l > AW) ? AW : cfg_l);
    for (int k = 0; k < (1 << l); k++) begin
      a     = brev ? rev_bits(k, l) : k;
      fr[a] = 32'(base + k);
      fi[a] = 32'(-(base + k));
    end
    q_re.push_back(fr);
    q_im.push_back(fi);
    q_l.push_back(l);
  endtask

  task automatic send_frame(input int cfg_l, input bit brev, input int base, input int n, input bit good);
    bus.cfg_log2n  = 3'(cfg_l);
    bus.cfg_bitrev = brev;
    for (int i = 0; i < n; i++) drive_sample(i == 0, i == n - 1, base + i);
    idle();
    if (good) push_model(cfg_l, brev, base);
  endtask

  task automatic wait_src();
    int n = 0;
    while (bus.source_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check_eq("source_ready_wait", 32'(bus.source_ready), 32'd1);
  endtask

  task automatic read_frame();
    frame_t fr;
    frame_t fi;
    int     l;
    wait_src();
    check_eq("sb_pending", 32'(q_l.size() > 0), 32'd1);
    if (q_l.size() == 0) return;
    fr = q_re.pop_front();
    fi = q_im.pop_front();
    l  = q_l.pop_front();
    check_eq("source_log2n", 32'(bus.source_log2n), 32'(l));
    for (int a = 0; a < (1 << l); a++) begin
      bus.source_rdaddr = 4'(a);
      tick();
      check_eq($sformatf("re[%0d]", a), bus.source_Re, fr[a]);
      check_eq($sformatf("im[%0d]", a), bus.source_Im, fi[a]);
    end
  endtask

  task automatic release_buf();
    bus.source_rdack = 1'b1;
    tick();
    bus.source_rdack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    aclr              = 1'b1;
    bus.cfg_log2n     = '0;
    bus.cfg_bitrev    = 1'b0;
    bus.sink_Re       = '0;
    bus.sink_Im       = '0;
    bus.source_rdaddr = '0;
    bus.source_rdack  = 1'b0;
    idle();
    repeat (3) tick();
    check_eq("rst_sink_ready",   32'(bus.sink_ready),   32'd1);
    check_eq("rst_source_ready", 32'(bus.source_ready), 32'd0);
    check_eq("rst_error",        32'(bus.error),        32'd0);
    check_eq("rst_err_code",     32'(bus.err_code),     32'd0);
    check_eq("rst_log2n",        32'(bus.source_log2n), 32'd0);
    aclr = 1'b0;
    tick();

    // bit-reversed L=4, commit lands exactly two cycles after eop
    send_frame(4, 1'b1, 0, 16, 1'b1);
    check_eq("commit_not_early", 32'(bus.source_ready), 32'd0);
    tick();
    check_eq("commit_at_2", 32'(bus.source_ready), 32'd1);
    read_frame();
    release_buf();

    // natural order, then a clamped length
    send_frame(3, 1'b0, 100, 8, 1'b1);
    read_frame();
    release_buf();
    send_frame(1, 1'b0, 200, 8, 1'b1);
    read_frame();
    release_buf();

    // sop strobe without valid
    bus.sink_sop = 1'b1;
    tick();
    idle();
    check_eq("strobe_err",      32'(bus.error),    32'd1);
    check_eq("strobe_err_code", 32'(bus.err_code), 32'd2);
    tick();
    check_eq("strobe_err_pulse", 32'(bus.error), 32'd0);

    // fill all buffers, then overflow
    send_frame(4, 1'b1, 1000, 16, 1'b1);
    send_frame(4, 1'b0, 1016, 16, 1'b1);
    send_frame(4, 1'b1, 1032, 16, 1'b1);
    check_eq("full_ready_low", 32'(bus.sink_ready), 32'd0);
    drive_sample(1'b1, 1'b0, 5000);
    idle();
    check_eq("ovf_error", 32'(bus.error),    32'd1);
    check_eq("ovf_code",  32'(bus.err_code), 32'd1);
    tick();
    read_frame();
    check_eq("full_still_low", 32'(bus.sink_ready), 32'd0);
    release_buf();
    check_eq("ready_after_rdack", 32'(bus.sink_ready), 32'd1);
    read_frame();
    release_buf();
    read_frame();
    release_buf();

    // short frame: framing error, no commit
    send_frame(4, 1'b0, 400, 10, 1'b0);
    check_eq("frame_error", 32'(bus.error),    32'd1);
    check_eq("frame_code",  32'(bus.err_code), 32'd2);
    repeat (3) tick();
    check_eq("no_commit", 32'(bus.source_ready), 32'd0);
    send_frame(4, 1'b1, 500, 16, 1'b1);
    read_frame();
    release_buf();

    // sop mid-frame restarts the frame
    bus.cfg_log2n  = 3'd4;
    bus.cfg_bitrev = 1'b1;
    for (int i = 0; i < 5; i++) drive_sample(i == 0, 1'b0, 50 + i);
    check_eq("partial_no_err", 32'(bus.error), 32'd0);
    drive_sample(1'b1, 1'b0, 300);
    check_eq("sop_error", 32'(bus.error),    32'd1);
    check_eq("sop_code",  32'(bus.err_code), 32'd3);
    for (int i = 1; i < 16; i++) drive_sample(1'b0, i == 15, 300 + i);
    idle();
    push_model(4, 1'b1, 300);
    read_frame();
    release_buf();

    // commit and rdack in the same cycle
    send_frame(4, 1'b0, 600, 16, 1'b1);
    read_frame();
    send_frame(4, 1'b1, 700, 16, 1'b1);
    check_eq("pre_same_ready", 32'(bus.source_ready), 32'd1);
    release_buf();
    check_eq("same_cycle_ready", 32'(bus.source_ready), 32'd1);
    tick();
    check_eq("same_cycle_ready2", 32'(bus.source_ready), 32'd1);
    check_eq("same_cycle_sink",   32'(bus.sink_ready),   32'd1);
    read_frame();

    // reset mid-frame
    bus.cfg_log2n = 3'd4;
    for (int i = 0; i < 5; i++) drive_sample(i == 0, 1'b0, 800 + i);
    idle();
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    check_eq("arst_source_ready", 32'(bus.source_ready), 32'd0);
    check_eq("arst_sink_ready",   32'(bus.sink_ready),   32'd1);
    check_eq("arst_error",        32'(bus.error),        32'd0);
    q_re.delete();
    q_im.delete();
    q_l.delete();
    send_frame(3, 1'b1, 900, 8, 1'b1);
    read_frame();
    release_buf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
